// File: rtl/pid_sched_pkg.sv
// rtl/pid_sched_pkg.sv - shared widths and FSM state encodings for the PID update scheduler
package pid_sched_pkg;

  localparam int PWM_W = 16;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE       = 3'd0;
  localparam sched_state_t ST_SELECT     = 3'd1;
  localparam sched_state_t ST_WAIT_FRESH = 3'd2;
  localparam sched_state_t ST_STROBE     = 3'd3;
  localparam sched_state_t ST_SETTLE     = 3'd4;
  localparam sched_state_t ST_CAPTURE    = 3'd5;
  localparam sched_state_t ST_NEXT       = 3'd6;
  localparam sched_state_t ST_DONE       = 3'd7;

  function automatic int motor_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pid_update_scheduler_if.sv
// rtl/pid_update_scheduler_if.sv - captured PWM reference stream towards the motor-command writer
interface pid_update_scheduler_if
  import pid_sched_pkg::*;
#(
  parameter int IDX_W = 3
);
  logic signed [PWM_W-1:0] pwm_out;
  logic [IDX_W-1:0]        pwm_motor;
  logic                    pwm_valid;

  modport master (output pwm_out, output pwm_motor, output pwm_valid);
  modport slave  (input  pwm_out, input  pwm_motor, input  pwm_valid);
endinterface

// File: rtl/pid_period_tick.sv
// rtl/pid_period_tick.sv - control-period counter; tick marks the cycle the counter wraps
module pid_period_tick #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);
endmodule

// File: rtl/pid_update_scheduler.sv
// rtl/pid_update_scheduler.sv - per-period PID update sequencer; define PID_SCHED_WATCHDOG_EN
// to add the consecutive-timeout watchdog that parks faulted motors at zero.
module pid_update_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int PERIOD_CYCLES    = 50000,
  parameter int FRESH_TIMEOUT    = 256,
  parameter int SETTLE_CYCLES    = 2,
  localparam int MOTOR_IDX_W     = motor_idx_w(NUMBER_OF_MOTORS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
  input  logic [NUMBER_OF_MOTORS-1:0] sensor_fresh,
  input  logic signed [PWM_W-1:0]     pwm_ref_in,
  output logic [MOTOR_IDX_W-1:0]      motor_sel,
  output logic [NUMBER_OF_MOTORS-1:0] update_controller,
  output logic                        sweep_done,
  output logic [NUMBER_OF_MOTORS-1:0] skipped,
  output logic                        overrun,
  input  logic                        overrun_clear,
  output logic [NUMBER_OF_MOTORS-1:0] fault,
  input  logic [NUMBER_OF_MOTORS-1:0] fault_clear,
  pid_update_scheduler_if.master      pwm_if
);
  localparam int TO_W = $clog2(FRESH_TIMEOUT + 1);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRESH_TIMEOUT - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [MOTOR_IDX_W-1:0] IDX_LAST = MOTOR_IDX_W'(NUMBER_OF_MOTORS - 1);
  localparam logic [NUMBER_OF_MOTORS-1:0] ONE_HOT0 = 1;

  sched_state_t              state;
  logic [MOTOR_IDX_W-1:0]    idx;
  logic [TO_W-1:0]           tcnt;
  logic [SC_W-1:0]           scnt;
  logic [NUMBER_OF_MOTORS-1:0] fresh_pending;
  logic signed [PWM_W-1:0]   pwm_out_r;
  logic [MOTOR_IDX_W-1:0]    pwm_motor_r;
  logic                      pwm_valid_r;
  logic                      tick;
  logic                      faulted;
  logic                      strobe_go;
  logic                      timeout_go;

  pid_period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign motor_sel        = idx;
  assign pwm_if.pwm_out   = pwm_out_r;
  assign pwm_if.pwm_motor = pwm_motor_r;
  assign pwm_if.pwm_valid = pwm_valid_r;

  assign strobe_go  = enable && state == ST_WAIT_FRESH && fresh_pending[idx];
  assign timeout_go = enable && state == ST_WAIT_FRESH && !fresh_pending[idx] && tcnt == TO_LAST;

  // A new measurement arriving in the strobe cycle must survive for the next sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fresh_pending <= '0;
    end else begin
      fresh_pending <= (fresh_pending & ~update_controller) | sensor_fresh;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tick && state != ST_IDLE) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

`ifdef PID_SCHED_WATCHDOG_EN
  logic [1:0] to_cnt [NUMBER_OF_MOTORS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault <= '0;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) to_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
        if (fault_clear[i]) begin
          fault[i]  <= 1'b0;
          to_cnt[i] <= 2'd0;
        end else if (strobe_go && idx == MOTOR_IDX_W'(i)) begin
          to_cnt[i] <= 2'd0;
        end else if (timeout_go && idx == MOTOR_IDX_W'(i)) begin
          if (to_cnt[i] != 2'd3) to_cnt[i] <= to_cnt[i] + 2'd1;
          if (to_cnt[i] == 2'd2) fault[i] <= 1'b1;
        end
      end
    end
  end

  assign faulted = fault[idx];
`else
  assign fault   = fault_clear & {NUMBER_OF_MOTORS{1'b0}};
  assign faulted = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      tcnt              <= '0;
      scnt              <= '0;
      update_controller <= '0;
      pwm_out_r         <= '0;
      pwm_motor_r       <= '0;
      pwm_valid_r       <= 1'b0;
      sweep_done        <= 1'b0;
      skipped           <= '0;
    end else begin
      update_controller <= '0;
      pwm_valid_r       <= 1'b0;
      sweep_done        <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tick) begin
              idx   <= '0;
              state <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            if (idx == '0) skipped <= '0;
            if (!motor_enable[idx]) begin
              state <= ST_NEXT;
            end else if (faulted) begin
              pwm_out_r   <= '0;
              pwm_motor_r <= idx;
              pwm_valid_r <= 1'b1;
              state       <= ST_CAPTURE;
            end else begin
              tcnt  <= '0;
              state <= ST_WAIT_FRESH;
            end
          end
          ST_WAIT_FRESH: begin
            if (fresh_pending[idx]) begin
              update_controller <= ONE_HOT0 << idx;
              state             <= ST_STROBE;
            end else if (tcnt == TO_LAST) begin
              skipped[idx] <= 1'b1;
              state        <= ST_NEXT;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          ST_STROBE: begin
            scnt  <= '0;
            state <= ST_SETTLE;
          end
          // Capture on the last settle edge so pwm_valid is visible during CAPTURE.
          ST_SETTLE: begin
            if (scnt == SC_LAST) begin
              pwm_out_r   <= pwm_ref_in;
              pwm_motor_r <= idx;
              pwm_valid_r <= 1'b1;
              state       <= ST_CAPTURE;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          ST_CAPTURE: state <= ST_NEXT;
          ST_NEXT: begin
            if (idx == IDX_LAST) begin
              sweep_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SELECT;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
